ps2_receiver: RTL and testbench

Receives device-to-host PS/2 frames from the keyboard pins and delivers validated scancode bytes over a valid/ready handshake to the input/logic stage. The pins are ps2_clk and ps2_dat. The block sits directly downstream of the top-level PS/2 pins and upstream of the logic stage (currently logic_placeholder), in the clk_25M175 domain. It handles synchronisation, glitch filtering, frame checking, timeout recovery and one-byte buffering.

---
 rtl/ps2_pkg.sv | 16 +
 rtl/ps2_input_sync.sv | 54 +++++
 rtl/ps2_receiver.sv | 186 ++++++++++++++++++
 tb/tb_ps2_receiver.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 device-to-host receiver.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_t;

  localparam int unsigned PS2_DATA_BITS       = 8;
  localparam logic        PS2_START_BIT       = 1'b0;
  localparam logic        PS2_STOP_BIT        = 1'b1;
  localparam int unsigned PS2_DEFAULT_TIMEOUT = 50000;

endpackage

// File: rtl/ps2_input_sync.sv
// PS/2 pin conditioning: 2-FF synchronisers on both pins, a glitch filter on
// the clock pin, and a one-cycle strobe on each filtered clock falling edge.
module ps2_input_sync #(
  parameter int unsigned FILTER_LEN = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clk_raw,
  input  logic dat_raw,
  output logic dat_sync,
  output logic clk_strobe
);

  localparam int unsigned      FCNT_W    = $clog2(FILTER_LEN + 1);
  localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FILTER_LEN - 1);

  logic              clk_meta;
  logic              clk_sync;
  logic              dat_meta;
  logic              clk_filt;
  logic [FCNT_W-1:0] filt_cnt;

  // Synchronise both pins; filtered clock follows the synced clock only after
  // FILTER_LEN consecutive disagreeing samples, strobing on a 1->0 change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_meta   <= 1'b1;
      clk_sync   <= 1'b1;
      dat_meta   <= 1'b1;
      dat_sync   <= 1'b1;
      clk_filt   <= 1'b1;
      filt_cnt   <= '0;
      clk_strobe <= 1'b0;
    end else begin
      clk_meta   <= clk_raw;
      clk_sync   <= clk_meta;
      dat_meta   <= dat_raw;
      dat_sync   <= dat_meta;
      clk_strobe <= 1'b0;
      if (clk_sync != clk_filt) begin
        if (filt_cnt == FCNT_LAST) begin
          clk_filt   <= clk_sync;
          filt_cnt   <= '0;
          clk_strobe <= ~clk_sync;
        end else begin
          filt_cnt <= filt_cnt + FCNT_W'(1);
        end
      end else begin
        filt_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/ps2_receiver.sv
// PS/2 device-to-host frame receiver with a one-byte valid/ready output buffer.
// Optional build macro PS2_RECEIVER_ERR_COUNT_EN adds a saturating error counter
// output err_count.
module ps2_receiver
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = 4,
  parameter int unsigned TIMEOUT_CYCLES = PS2_DEFAULT_TIMEOUT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] data,
  output logic       data_valid,
  input  logic       data_ready,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overflow
`ifdef PS2_RECEIVER_ERR_COUNT_EN
  ,
  output logic [7:0] err_count
`endif
);

  localparam int unsigned       TMO_W    = $clog2(TIMEOUT_CYCLES);
  localparam int unsigned       BIT_W    = $clog2(PS2_DATA_BITS);
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(PS2_DATA_BITS - 1);

  logic dat_sync;
  logic strobe;

  ps2_state_t               state, state_n;
  logic [BIT_W-1:0]         bit_cnt, bit_cnt_n;
  logic [PS2_DATA_BITS-1:0] shreg, shreg_n;
  logic                     par_bit, par_bit_n;
  logic [TMO_W-1:0]         tmo_cnt, tmo_cnt_n;
  logic [7:0]               data_n;
  logic                     data_valid_n;
  logic                     parity_err_n;
  logic                     frame_err_n;
  logic                     overflow_n;
  logic                     byte_done;
  logic                     drop;
  logic                     timeout_hit;
`ifdef PS2_RECEIVER_ERR_COUNT_EN
  logic [7:0]               err_count_n;
`endif

  ps2_input_sync #(
    .FILTER_LEN (FILTER_LEN)
  ) u_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .clk_raw    (ps2_clk),
    .dat_raw    (ps2_dat),
    .dat_sync   (dat_sync),
    .clk_strobe (strobe)
  );

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      tmo_cnt    <= '0;
      data       <= 8'h00;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overflow   <= 1'b0;
`ifdef PS2_RECEIVER_ERR_COUNT_EN
      err_count  <= 8'h00;
`endif
    end else begin
      state      <= state_n;
      bit_cnt    <= bit_cnt_n;
      shreg      <= shreg_n;
      par_bit    <= par_bit_n;
      tmo_cnt    <= tmo_cnt_n;
      data       <= data_n;
      data_valid <= data_valid_n;
      parity_err <= parity_err_n;
      frame_err  <= frame_err_n;
      overflow   <= overflow_n;
`ifdef PS2_RECEIVER_ERR_COUNT_EN
      err_count  <= err_count_n;
`endif
    end
  end

  // Frame FSM, timeout recovery and output buffer next-state logic.
  always_comb begin
    state_n      = state;
    bit_cnt_n    = bit_cnt;
    shreg_n      = shreg;
    par_bit_n    = par_bit;
    tmo_cnt_n    = tmo_cnt;
    data_n       = data;
    data_valid_n = data_valid;
    parity_err_n = 1'b0;
    frame_err_n  = 1'b0;
    overflow_n   = overflow;
    byte_done    = 1'b0;
    drop         = 1'b0;
    timeout_hit  = (state != IDLE) && !strobe && (tmo_cnt == TMO_LAST);

    if (strobe || state == IDLE) begin
      tmo_cnt_n = '0;
    end else begin
      tmo_cnt_n = tmo_cnt + TMO_W'(1);
    end

    case (state)
      IDLE: begin
        if (strobe) begin
          if (dat_sync == PS2_START_BIT) begin
            state_n   = DATA;
            bit_cnt_n = '0;
          end else begin
            frame_err_n = 1'b1;
          end
        end
      end
      DATA: begin
        if (strobe) begin
          shreg_n   = {dat_sync, shreg[PS2_DATA_BITS-1:1]};
          bit_cnt_n = bit_cnt + BIT_W'(1);
          if (bit_cnt == BIT_LAST) begin
            state_n = PARITY;
          end
        end
      end
      PARITY: begin
        if (strobe) begin
          par_bit_n = dat_sync;
          state_n   = STOP;
        end
      end
      STOP: begin
        if (strobe) begin
          state_n = IDLE;
          if (dat_sync != PS2_STOP_BIT) begin
            frame_err_n = 1'b1;
          end else if (^{shreg, par_bit} != 1'b1) begin
            parity_err_n = 1'b1;
          end else begin
            byte_done = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // A stalled frame is abandoned and its partial byte discarded.
    if (timeout_hit) begin
      state_n     = IDLE;
      bit_cnt_n   = '0;
      shreg_n     = '0;
      frame_err_n = 1'b1;
    end

    if (byte_done) begin
      if (!data_valid || data_ready) begin
        data_n       = shreg;
        data_valid_n = 1'b1;
      end else begin
        drop       = 1'b1;
        overflow_n = 1'b1;
      end
    end else if (data_valid && data_ready) begin
      data_valid_n = 1'b0;
    end

`ifdef PS2_RECEIVER_ERR_COUNT_EN
    err_count_n = err_count;
    if ((parity_err_n || frame_err_n || drop) && (err_count != 8'hFF)) begin
      err_count_n = err_count + 8'd1;
    end
`endif
  end

endmodule

// File: tb/tb_ps2_receiver.sv
// Directed bench for ps2_receiver: table of whole frames plus hand-written
// sequences for buffering, timeout, glitch rejection and mid-frame reset.
module tb_ps2_receiver;

  localparam int unsigned TIMEOUT_CYCLES = 50000;

  logic       clk;
  logic       rst_n;
  logic       ps2_clk;
  logic       ps2_dat;
  logic [7:0] data;
  logic       data_valid;
  logic       data_ready;
  logic       parity_err;
  logic       frame_err;
  logic       overflow;
`ifdef PS2_RECEIVER_ERR_COUNT_EN
  logic [7:0] err_count;
`endif

  ps2_receiver #(
    .FILTER_LEN     (4),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ps2_clk    (ps2_clk),
    .ps2_dat    (ps2_dat),
    .data       (data),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overflow   (overflow)
`ifdef PS2_RECEIVER_ERR_COUNT_EN
    ,
    .err_count  (err_count)
`endif
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  int cyc = 0;
  int hs_cnt = 0;
  int pe_cnt = 0;
  int fe_cnt = 0;
  logic [7:0] last_hs_data = 8'h00;
  int last_fall_cyc = 0;
  int n_total = 0;
  int n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Observe handshakes and error pulse cycles away from the active edge.
  always @(negedge clk) begin
    if (data_valid && data_ready) begin
      hs_cnt       <= hs_cnt + 1;
      last_hs_data <= data;
    end
    if (parity_err) pe_cnt <= pe_cnt + 1;
    if (frame_err)  fe_cnt <= fe_cnt + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Emit the first nfall bits of a frame (start, 8 data LSB-first, parity, stop).
  task automatic send_frame(input logic [7:0] b, input logic pflip, input logic stop_bit,
                            input int nfall);
    logic [10:0] f;
    f = {stop_bit, (~^b) ^ pflip, b, 1'b0};
    for (int i = 0; i < nfall; i++) begin
      ps2_dat = f[i];
      tick(8);
      ps2_clk = 1'b0;
      last_fall_cyc = cyc;
      tick(16);
      ps2_clk = 1'b1;
      tick(8);
    end
    ps2_dat = 1'b1;
  endtask

  typedef struct {
    logic [7:0] dbyte;
    logic       pflip;
    logic       stop_bit;
    int         exp_acc;
    int         exp_pe;
    int         exp_fe;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int hs0, pe0, fe0;
    bit found;
    int elapsed;

    vecs[0] = '{8'h1C, 1'b0, 1'b1, 1, 0, 0, 8'h1C};
    vecs[1] = '{8'h1C, 1'b1, 1'b1, 0, 1, 0, 8'h00};
    vecs[2] = '{8'h1C, 1'b0, 1'b0, 0, 0, 1, 8'h00};
    vecs[3] = '{8'h5A, 1'b0, 1'b1, 1, 0, 0, 8'h5A};
    vecs[4] = '{8'h00, 1'b0, 1'b1, 1, 0, 0, 8'h00};
    vecs[5] = '{8'hFF, 1'b0, 1'b1, 1, 0, 0, 8'hFF};
    vecs[6] = '{8'hA5, 1'b1, 1'b0, 0, 0, 1, 8'h00};
    vecs[7] = '{8'h80, 1'b0, 1'b1, 1, 0, 0, 8'h80};

    rst_n = 1'b0;
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    data_ready = 1'b0;
    tick(3);
    check("rst_data", 32'(data), 32'h00);
    check("rst_valid", 32'(data_valid), 32'h0);
    check("rst_parity_err", 32'(parity_err), 32'h0);
    check("rst_frame_err", 32'(frame_err), 32'h0);
    check("rst_overflow", 32'(overflow), 32'h0);
    rst_n = 1'b1;
    tick(5);

    // Whole frames with the consumer always ready.
    data_ready = 1'b1;
    for (int v = 0; v < 8; v++) begin
      hs0 = hs_cnt; pe0 = pe_cnt; fe0 = fe_cnt;
      send_frame(vecs[v].dbyte, vecs[v].pflip, vecs[v].stop_bit, 11);
      tick(20);
      check($sformatf("vec%0d_accepts", v), 32'(hs_cnt - hs0), 32'(vecs[v].exp_acc));
      check($sformatf("vec%0d_parity_err_cycles", v), 32'(pe_cnt - pe0), 32'(vecs[v].exp_pe));
      check($sformatf("vec%0d_frame_err_cycles", v), 32'(fe_cnt - fe0), 32'(vecs[v].exp_fe));
      check($sformatf("vec%0d_valid_after", v), 32'(data_valid), 32'h0);
      if (vecs[v].exp_acc == 1)
        check($sformatf("vec%0d_data", v), 32'(last_hs_data), 32'(vecs[v].exp_data));
    end
    check("overflow_clear_after_table", 32'(overflow), 32'h0);

    // Buffer full: second byte dropped, first held, overflow sticky.
    data_ready = 1'b0;
    send_frame(8'hF0, 1'b0, 1'b1, 11);
    tick(10);
    send_frame(8'h1C, 1'b0, 1'b1, 11);
    tick(10);
    check("ovf_data_held", 32'(data), 32'hF0);
    check("ovf_valid_held", 32'(data_valid), 32'h1);
    check("ovf_flag", 32'(overflow), 32'h1);
    hs0 = hs_cnt;
    data_ready = 1'b1;
    tick(2);
    check("ovf_valid_drop", 32'(data_valid), 32'h0);
    check("ovf_handshakes", 32'(hs_cnt - hs0), 32'h1);
    check("ovf_hs_data", 32'(last_hs_data), 32'hF0);
    tick(20);
    check("ovf_sticky", 32'(overflow), 32'h1);

    // Stall after 4 data bits; expect a frame_err near TIMEOUT_CYCLES.
    fe0 = fe_cnt;
    send_frame(8'h29, 1'b0, 1'b1, 5);
    found = 1'b0;
    elapsed = 0;
    for (int k = 0; k < 60000; k++) begin
      tick(1);
      if (frame_err) begin
        found = 1'b1;
        elapsed = cyc - last_fall_cyc;
        break;
      end
    end
    check("timeout_seen", 32'(found), 32'h1);
    check("timeout_latency_in_window",
          32'((elapsed >= int'(TIMEOUT_CYCLES)) && (elapsed <= int'(TIMEOUT_CYCLES) + 12)), 32'h1);
    tick(3);
    check("timeout_single_pulse", 32'(fe_cnt - fe0), 32'h1);
    hs0 = hs_cnt; pe0 = pe_cnt; fe0 = fe_cnt;
    send_frame(8'h29, 1'b0, 1'b1, 11);
    tick(20);
    check("post_timeout_accept", 32'(hs_cnt - hs0), 32'h1);
    check("post_timeout_data", 32'(last_hs_data), 32'h29);
    check("post_timeout_errs", 32'((pe_cnt - pe0) + (fe_cnt - fe0)), 32'h0);

    // Short low glitches in IDLE must not strobe (a strobe with dat=1 would frame_err).
    hs0 = hs_cnt; fe0 = fe_cnt;
    for (int g = 1; g <= 3; g++) begin
      ps2_clk = 1'b0;
      tick(g);
      ps2_clk = 1'b1;
      tick(10);
    end
    check("glitch_no_frame_err", 32'(fe_cnt - fe0), 32'h0);
    check("glitch_no_accept", 32'(hs_cnt - hs0), 32'h0);

    // Mid-frame asynchronous reset with a byte pending.
    data_ready = 1'b0;
    send_frame(8'h77, 1'b0, 1'b1, 11);
    tick(10);
    check("pre_reset_valid", 32'(data_valid), 32'h1);
    send_frame(8'h33, 1'b0, 1'b1, 4);
    tick(3);
    rst_n = 1'b0;
    #1;
    check("midrst_data", 32'(data), 32'h00);
    check("midrst_valid", 32'(data_valid), 32'h0);
    check("midrst_overflow", 32'(overflow), 32'h0);
    check("midrst_parity_err", 32'(parity_err), 32'h0);
    check("midrst_frame_err", 32'(frame_err), 32'h0);
    tick(3);
    rst_n = 1'b1;
    tick(5);
    data_ready = 1'b1;
    hs0 = hs_cnt; pe0 = pe_cnt; fe0 = fe_cnt;
    send_frame(8'h1C, 1'b0, 1'b1, 11);
    tick(20);
    check("post_reset_accept", 32'(hs_cnt - hs0), 32'h1);
    check("post_reset_data", 32'(last_hs_data), 32'h1C);
    check("post_reset_errs", 32'((pe_cnt - pe0) + (fe_cnt - fe0)), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
